jzjpcc_operand_stage: RTL and testbench

Parametrised successor to the execute-stage ALU operand mux. It selects ALU operands A/B and store data for the execute stage, resolves RAW hazards by forwarding from up to `NUM_FWD` younger pipeline stages, and stalls on not-yet-ready forwarded data such as load-use. Results go into a registered, valid/ready-handshaked output slot that feeds the ALU.

---
 rtl/jzjpcc_operand_stage.sv | 128 ++++++++++++
 tb/tb_jzjpcc_operand_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_operand_stage.sv
// rtl/jzjpcc_operand_stage.sv - execute-stage operand mux with forwarding, hazard stall and registered output slot
// Optional feature: define JZJPCC_OPERAND_FORWARDING_EN to enable forwarding and the hazard stall.
module jzjpcc_operand_stage #(
    parameter int PC_MAX_B = 31,
    parameter int NUM_FWD  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [1:0]             aluMuxMode,
    input  logic [4:0]             rs1Addr,
    input  logic [4:0]             rs2Addr,
    input  logic [31:0]            rs1,
    input  logic [31:0]            rs2,
    input  logic [31:0]            immediate,
    input  logic [PC_MAX_B:2]      currentPC,
    input  logic [NUM_FWD-1:0]     fwdValid,
    input  logic [5*NUM_FWD-1:0]   fwdRdAddr,
    input  logic [NUM_FWD-1:0]     fwdDataReady,
    input  logic [32*NUM_FWD-1:0]  fwdData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [31:0]            aluOperandA,
    output logic [31:0]            aluOperandB,
    output logic [31:0]            storeData
);

    logic [31:0] pc_ext;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        rs1_haz;
    logic        rs2_haz;
    logic        hazard;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;

    logic        out_valid_q, out_valid_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] store_q, store_d;

    assign pc_ext = 32'({currentPC, 2'b00});

`ifdef JZJPCC_OPERAND_FORWARDING_EN
    // Walk from the oldest source to the youngest so the lowest matching index wins.
    always_comb begin
        rs1_val = rs1;
        rs2_val = rs2;
        rs1_haz = 1'b0;
        rs2_haz = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if ((rs1Addr != 5'd0) && fwdValid[i] && (fwdRdAddr[5*i +: 5] == rs1Addr)) begin
                rs1_val = fwdData[32*i +: 32];
                rs1_haz = !fwdDataReady[i];
            end
            if ((rs2Addr != 5'd0) && fwdValid[i] && (fwdRdAddr[5*i +: 5] == rs2Addr)) begin
                rs2_val = fwdData[32*i +: 32];
                rs2_haz = !fwdDataReady[i];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwdValid, fwdRdAddr, fwdDataReady, fwdData, rs1Addr, rs2Addr};

    always_comb begin
        rs1_val = rs1;
        rs2_val = rs2;
        rs1_haz = 1'b0;
        rs2_haz = 1'b0;
    end
`endif

    // Register operands only matter in modes 00/01; PC modes never stall.
    assign hazard = !aluMuxMode[1] && (rs1_haz || rs2_haz);

    always_comb begin
        sel_a = aluMuxMode[1] ? pc_ext : rs1_val;
        case (aluMuxMode)
            2'b00:   sel_b = rs2_val;
            2'b10:   sel_b = 32'd4;
            default: sel_b = immediate;
        endcase
    end

    assign inReady = !(inValid && hazard) && (!out_valid_q || outReady);
    assign accept  = inValid && inReady && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        store_d     = store_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            op_a_d      = sel_a;
            op_b_d      = sel_b;
            store_d     = rs2_val;
        end else if (out_valid_q && outReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            store_q     <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            store_q     <= store_d;
        end
    end

    assign outValid    = out_valid_q;
    assign aluOperandA = op_a_q;
    assign aluOperandB = op_b_q;
    assign storeData   = store_q;

endmodule

// File: tb/tb_jzjpcc_operand_stage.sv
// tb/tb_jzjpcc_operand_stage.sv - self-checking bench for jzjpcc_operand_stage
module tb_jzjpcc_operand_stage;

    localparam int PC_MAX_B = 31;
    localparam int NUM_FWD  = 2;
`ifdef JZJPCC_OPERAND_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            mode;
    logic [4:0]            rs1_addr;
    logic [4:0]            rs2_addr;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic [31:0]           imm;
    logic [PC_MAX_B:2]     current_pc;
    logic [NUM_FWD-1:0]    fwd_valid;
    logic [5*NUM_FWD-1:0]  fwd_rd_addr;
    logic [NUM_FWD-1:0]    fwd_data_ready;
    logic [32*NUM_FWD-1:0] fwd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           op_a;
    logic [31:0]           op_b;
    logic [31:0]           store_data;

    int errors = 0;
    int checks = 0;

    // Reference slot state and the value it takes at the next edge
    bit          m_valid, n_valid, m_ready;
    logic [31:0] m_a, m_b, m_sd, n_a, n_b, n_sd;

    jzjpcc_operand_stage #(.PC_MAX_B(PC_MAX_B), .NUM_FWD(NUM_FWD)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .inValid(in_valid), .inReady(in_ready), .aluMuxMode(mode),
        .rs1Addr(rs1_addr), .rs2Addr(rs2_addr), .rs1(rs1), .rs2(rs2),
        .immediate(imm), .currentPC(current_pc),
        .fwdValid(fwd_valid), .fwdRdAddr(fwd_rd_addr),
        .fwdDataReady(fwd_data_ready), .fwdData(fwd_data),
        .outValid(out_valid), .outReady(out_ready),
        .aluOperandA(op_a), .aluOperandB(op_b), .storeData(store_data)
    );

    always #5 clock = ~clock;

    function automatic void resolve(input logic [4:0] addr, input logic [31:0] rf,
                                    output logic [31:0] v, output bit haz);
        v   = rf;
        haz = 1'b0;
        if (FWD_EN && addr != 5'd0) begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (fwd_valid[i] && fwd_rd_addr[5*i +: 5] == addr) begin
                    v   = fwd_data[32*i +: 32];
                    haz = !fwd_data_ready[i];
                    break;
                end
            end
        end
    endfunction

    task automatic model_eval();
        logic [31:0] r1, r2, a, b, pc;
        bit h1, h2, haz;
        resolve(rs1_addr, rs1, r1, h1);
        resolve(rs2_addr, rs2, r2, h2);
        pc  = {current_pc, 2'b00};
        haz = 1'b0;
        case (mode)
            2'd0: begin a = r1; b = r2;  haz = h1 | h2; end
            2'd1: begin a = r1; b = imm; haz = h1 | h2; end
            2'd2: begin a = pc; b = 32'd4; end
            default: begin a = pc; b = imm; end
        endcase
        m_ready = !(in_valid && haz) && (!m_valid || out_ready);
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_sd = m_sd;
        if (reset) begin
            n_valid = 1'b0; n_a = '0; n_b = '0; n_sd = '0;
        end else if (flush) begin
            n_valid = 1'b0;
        end else if (in_valid && m_ready) begin
            n_valid = 1'b1; n_a = a; n_b = b; n_sd = r2;
        end else if (m_valid && out_ready) begin
            n_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_sd = n_sd;
        #1;
    endtask

    task automatic set_idle();
        reset = 0; flush = 0; in_valid = 0; mode = 0;
        rs1_addr = 0; rs2_addr = 0; rs1 = 0; rs2 = 0; imm = 0; current_pc = '0;
        fwd_valid = 0; fwd_rd_addr = 0; fwd_data_ready = 0; fwd_data = 0;
        out_ready = 1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++;
        if ({op_a, op_b, store_data} !== 96'd0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", op_a, op_b, store_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_pc_mode();
        set_idle();
        mode = 2'b10; current_pc = 30'h40; in_valid = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'h100 || op_b !== 32'd4) begin
            errors++; $display("FAIL pc_mode got v=%0b a=%h b=%h exp v=1 a=00000100 b=00000004", out_valid, op_a, op_b);
        end
        in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL pc_consume got=%0b exp=0", out_valid); end
    endtask

    task automatic test_forward_priority();
        logic [31:0] exp_a;
        set_idle();
        mode = 2'b00; rs1_addr = 5; rs1 = 32'hAAAA; rs2 = 32'h5;
        fwd_valid = 2'b11; fwd_rd_addr = {5'd5, 5'd5}; fwd_data_ready = 2'b11;
        fwd_data = {32'h22, 32'h11}; in_valid = 1;
        tick();
        exp_a = FWD_EN ? 32'h11 : 32'hAAAA;
        checks++;
        if (out_valid !== 1'b1 || op_a !== exp_a) begin
            errors++; $display("FAIL fwd_priority got v=%0b a=%h exp v=1 a=%h", out_valid, op_a, exp_a);
        end
        rs1_addr = 0; fwd_rd_addr = {5'd0, 5'd0};
        tick();
        checks++;
        if (op_a !== 32'hAAAA) begin errors++; $display("FAIL fwd_x0 got=%h exp=0000aaaa", op_a); end
        in_valid = 0;
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] exp_a;
        set_idle();
        mode = 2'b01; rs1_addr = 7; rs1 = 32'h1234; imm = 32'h8;
        fwd_valid = 2'b01; fwd_rd_addr = {5'd0, 5'd7}; fwd_data_ready = 2'b00;
        fwd_data = {32'h0, 32'hBEEF}; in_valid = 1;
        #1;
        checks++;
        if (in_ready !== !FWD_EN) begin errors++; $display("FAIL loaduse_stall got=%0b exp=%0b", in_ready, !FWD_EN); end
        tick();
        checks++;
        if (out_valid !== !FWD_EN) begin errors++; $display("FAIL loaduse_bubble got=%0b exp=%0b", out_valid, !FWD_EN); end
        fwd_data_ready = 2'b01; fwd_data = {32'h0, 32'hDEAD};
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_release got=%0b exp=1", in_ready); end
        tick();
        exp_a = FWD_EN ? 32'hDEAD : 32'h1234;
        checks++;
        if (out_valid !== 1'b1 || op_a !== exp_a || op_b !== 32'h8) begin
            errors++; $display("FAIL loaduse_data got v=%0b a=%h b=%h exp v=1 a=%h b=00000008", out_valid, op_a, op_b, exp_a);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_gated_hazard();
        set_idle();
        mode = 2'b11; rs1_addr = 3; current_pc = 30'h21; imm = 32'hFFFF_FFF0;
        fwd_valid = 2'b01; fwd_rd_addr = {5'd0, 5'd3}; fwd_data_ready = 2'b00; in_valid = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL gated_ready got=%0b exp=1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'h84 || op_b !== 32'hFFFF_FFF0) begin
            errors++; $display("FAIL gated_data got v=%0b a=%h b=%h exp v=1 a=00000084 b=fffffff0", out_valid, op_a, op_b);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        set_idle();
        rs1 = 32'hA1; rs2 = 32'hB1; in_valid = 1;
        tick();
        out_ready = 0; rs1 = 32'hA2; rs2 = 32'hB2;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", c, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || op_a !== 32'hA1 || op_b !== 32'hB1 || store_data !== 32'hB1) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%0b a=%h b=%h sd=%h exp v=1 a=a1 b=b1 sd=b1", c, out_valid, op_a, op_b, store_data);
            end
        end
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got=%0b exp=1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'hA2) begin errors++; $display("FAIL b2b_first got v=%0b a=%h exp v=1 a=a2", out_valid, op_a); end
        rs1 = 32'hA3;
        tick();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'hA3) begin errors++; $display("FAIL b2b_second got v=%0b a=%h exp v=1 a=a3", out_valid, op_a); end
    endtask

    task automatic test_flush();
        flush = 1; in_valid = 1; out_ready = 0; rs1 = 32'hF0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || op_a !== 32'hA3) begin
            errors++; $display("FAIL flush got v=%0b a=%h exp v=0 a=a3", out_valid, op_a);
        end
        flush = 0; in_valid = 0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nocapture got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_hold();
        set_idle();
        rs1 = 32'h77; in_valid = 1;
        tick();
        out_ready = 0; reset = 1;
        tick();
        reset = 0;
        checks++;
        if (out_valid !== 1'b0 || op_a !== 32'd0) begin
            errors++; $display("FAIL reset_hold got v=%0b a=%h exp v=0 a=0", out_valid, op_a);
        end
        in_valid = 0; out_ready = 1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            mode           = 2'($urandom_range(0, 3));
            rs1_addr       = 5'($urandom_range(0, 3));
            rs2_addr       = 5'($urandom_range(0, 3));
            rs1            = $urandom;
            rs2            = $urandom;
            imm            = $urandom;
            current_pc     = 30'($urandom);
            fwd_valid      = 2'($urandom);
            fwd_rd_addr    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            fwd_data_ready = 2'($urandom);
            fwd_data       = {$urandom, $urandom};
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 15) == 0);
            reset          = ($urandom_range(0, 31) == 0);
            #1;
            model_eval();
            checks++;
            if (in_ready !== m_ready) begin errors++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, in_ready, m_ready); end
            tick();
            checks++;
            if (out_valid !== m_valid || op_a !== m_a || op_b !== m_b || store_data !== m_sd) begin
                errors++;
                $display("FAIL rand_slot cyc=%0d got v=%0b a=%h b=%h sd=%h exp v=%0b a=%h b=%h sd=%h",
                         c, out_valid, op_a, op_b, store_data, m_valid, m_a, m_b, m_sd);
            end
        end
    endtask

    initial begin
        m_valid = 0; m_a = 0; m_b = 0; m_sd = 0;
        test_reset();
        test_pc_mode();
        test_forward_priority();
        test_load_use();
        test_gated_hazard();
        test_backpressure();
        test_flush();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
